// File: rtl/div_seq_ctrl.sv
// Sequencing controller for an 8-bit repeated-subtraction divider.
// It accepts a dividend/divisor pair under a start/done/ack handshake and
// drives the load and subtract strobes of an external remainder register.
// The fed-back remainder is compared against the divisor, subtractions are
// counted into the quotient, a zero divisor is flagged, and the results are
// held until they are acknowledged.
module div_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         ack,
  input  logic [W-1:0] rem_q,
  output logic         rem_ld,
  output logic         rem_upd,
  output logic [W-1:0] rem_din,
  output logic [W-1:0] rem_d,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t       state;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] q;

  // The captured operands feed the datapath directly and stay put until the
  // next accepted request.
  assign rem_din = op_a;
  assign rem_d   = op_b;

  // Controller FSM. The strobes and the status flags are registered together
  // with the state they belong to, so each one is high for exactly the cycles
  // its state occupies. The counter q cannot wrap: the largest quotient,
  // all-ones / 1, is exactly all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      q         <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      rem_ld    <= 1'b0;
      rem_upd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rem_ld  <= 1'b0;
      rem_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a <= dividend;
            op_b <= divisor;
            q    <= '0;
            if (divisor == '0) begin
              // Zero divisor: finish right away and leave the datapath alone.
              state     <= DONE;
              done      <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state    <= LOAD;
              rem_ld   <= 1'b1;
              busy     <= 1'b1;
              div_zero <= 1'b0;
            end
          end
        end
        LOAD: begin
          state <= CHECK;
        end
        CHECK: begin
          // rem_q has settled by now, because the register acted on the
          // previous cycle's strobe at its negedge.
          if (rem_q >= op_b) begin
            state   <= SUB;
            rem_upd <= 1'b1;
          end else begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q;
            remainder <= rem_q;
          end
        end
        SUB: begin
          q     <= q + W'(1);
          state <= CHECK;
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencing controller for the 8-bit repeated-subtraction divider. It accepts a dividend/divisor pair under a start/done/ack handshake and drives the load and update strobes of the remainder register. It compares the fed-back remainder against the divisor, counts subtractions into the quotient, flags divide-by-zero, and holds results until acknowledged. It sits between the requesting unit and the remainder-register datapath.

## Interface

- W, 8, operand, quotient and remainder width
- clk  in  1  clock; all controller state updates on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- dividend  in  W  dividend, captured when start is accepted
- divisor  in  W  divisor, captured when start is accepted
- ack  in  1  result consumed; sampled only in DONE
- rem_q  in  W  current remainder value fed back from the remainder register
- rem_ld  out  1  remainder-register load strobe; datapath loads rem_din
- rem_upd  out  1  remainder-register subtract strobe; datapath does R <= R - rem_d
- rem_din  out  W  captured dividend, driven to the datapath
- rem_d  out  W  captured divisor, driven to the datapath
- busy  out  1  high in LOAD, CHECK and SUB
- done  out  1  high in DONE
- quotient  out  W  result quotient
- remainder  out  W  result remainder
- div_zero  out  1  divisor was zero; valid while done is high

## Operation

- States: IDLE, LOAD, CHECK, SUB, DONE. All outputs are registered or decoded from state only.
- IDLE, start=1:
  - Capture dividend into op_a and divisor into op_b.
  - Clear the quotient counter q.
  - If divisor==0: go to DONE with div_zero=1, quotient=all-ones, remainder=dividend. The datapath is not touched.
  - Otherwise go to LOAD.
- LOAD: rem_ld=1 for exactly this cycle; next state is CHECK.
- CHECK (unsigned compare):
  - rem_q >= op_b: go to SUB.
  - Otherwise: latch remainder=rem_q and quotient=q, then go to DONE.
- SUB: rem_upd=1 for exactly this cycle; q <= q+1; next state is CHECK.
- DONE: done=1; quotient, remainder and div_zero are held stable. ack=1 returns to IDLE; done falls on the same edge.
- Ignored inputs:
  - start is ignored outside IDLE, including start held high through DONE.
  - A new request needs start high in IDLE.
  - ack is ignored outside DONE.
- rem_ld and rem_upd are never high in the same cycle. Neither is high in IDLE or DONE.
- The quotient counter is W bits. The maximum is 2^W-1 (dividend all-ones, divisor 1), so it never wraps.
- rem_din and rem_d stay constant from acceptance until the next acceptance.

## Timing

- Datapath contract:
  - The remainder register acts on rem_ld/rem_upd at the negedge inside the cycle the strobe is high.
  - rem_q is therefore settled by the following posedge.
  - The controller samples rem_q only in CHECK.
- Edge numbering: edge 0 is the posedge that accepts start.
- Non-zero divisor with quotient Q:
  - LOAD occupies the cycle after edge 0.
  - Each subtraction costs 2 cycles (SUB, CHECK).
  - done rises at edge 2Q+2; busy is high from edge 0 to edge 2Q+2.
- Zero divisor: done and div_zero rise at edge 0; busy never rises.
- ack high in the first done cycle: IDLE at the next edge, so minimum done width is 1 cycle.
- Back-to-back requests: start may be accepted at the first IDLE edge after ack.
- rst:
  - Any state goes to IDLE at the next edge, mid-operation included.
  - At and after a reset edge, all of the following are 0: busy, done, div_zero, quotient, remainder, rem_ld, rem_upd, rem_din, rem_d, q.
  - start high during the reset edge is dropped.

## Test plan

- 100/7 -> 14 rem_upd pulses; done at edge 30; quotient=14, remainder=2, div_zero=0.
- 5/9 -> one rem_ld pulse, no rem_upd; done at edge 2; quotient=0, remainder=5. Also 9/9 -> quotient=1, remainder=0, done at edge 4.
- 255/1 -> 255 rem_upd pulses; done at edge 512; quotient=255, remainder=0; no wrap of q.
- 42/0 -> done and div_zero at edge 0; quotient=255, remainder=42; rem_ld and rem_upd never asserted. A following 42/6 gives quotient=7, remainder=0, div_zero=0.
- Handshake:
  - start pulses during busy and during DONE are ignored; results stay stable for 10 cycles with ack low.
  - ack pulsed in CHECK has no effect.
  - ack in DONE -> IDLE next edge.
- rst asserted during the SUB of 200/3 (after 20 subtractions) -> next edge: IDLE with all outputs 0. A subsequent 200/3 completes with quotient=66, remainder=2.
